// File: rtl/bus_ram_responder_if.sv
// rtl/bus_ram_responder_if.sv - single-channel memory bus between an initiator and a RAM target
interface bus_ram_responder_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        write;
  logic        enable;
  logic [31:0] rdata;
  logic        ready;

  modport master (output addr, wdata, wstrb, write, enable, input rdata, ready);
  modport slave  (input addr, wdata, wstrb, write, enable, output rdata, ready);
endinterface

// File: rtl/bus_ram_responder.sv
// rtl/bus_ram_responder.sv - RAM target with per-direction wait states and one ready pulse per request
module bus_ram_responder #(
  parameter logic [31:0] BASE_ADDR     = 32'h0001_0000,
  parameter int          ADDR_WIDTH    = 10,
  parameter int          READ_LATENCY  = 1,
  parameter int          WRITE_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bus_ram_responder_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0]  RD_LOAD = 4'(READ_LATENCY - 1);
  localparam logic [3:0]  WR_LOAD = 4'(WRITE_LATENCY - 1);
  localparam logic [32:0] BASE33  = {1'b0, BASE_ADDR};
  localparam logic [32:0] LIMIT33 = BASE33 + (33'd4 << ADDR_WIDTH);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        write_q, write_d;

  logic [31:0] mem [2**ADDR_WIDTH];

  logic [32:0]           addr33;
  logic [31:0]           offset;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  in_range;
  logic                  do_commit;
  logic                  offset_unused;

  // Decode in 33 bits so a window touching the top of the address space cannot wrap.
  assign addr33        = {1'b0, addr_q};
  assign in_range      = (addr33 >= BASE33) && (addr33 < LIMIT33);
  assign offset        = addr_q - BASE_ADDR;
  assign word_idx      = offset[ADDR_WIDTH+1:2];
  assign offset_unused = ^{offset[31:ADDR_WIDTH+2], offset[1:0]};

  assign do_commit = (state_q == RESP) && bus.enable && write_q && in_range;
  assign bus.ready = (state_q == RESP);
  assign bus.rdata = ((state_q == RESP) && !write_q && in_range) ? mem[word_idx] : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'h0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      write_q <= write_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    write_d = write_q;
    case (state_q)
      IDLE: begin
        if (bus.enable) begin
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          wstrb_d = bus.wstrb;
          write_d = bus.write;
          cnt_d   = bus.write ? WR_LOAD : RD_LOAD;
          state_d = (cnt_d != 4'd0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (!bus.enable) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem[word_idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_bus_ram_responder.sv
// tb/tb_bus_ram_responder.sv - table-driven scoreboard bench for bus_ram_responder
module tb_bus_ram_responder;
  localparam logic [31:0] BASE = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        write, en;
  int          sel;
  logic        ready;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  bus_ram_responder_if bus0();
  bus_ram_responder_if bus1();

  assign bus0.addr   = addr;
  assign bus0.wdata  = wdata;
  assign bus0.wstrb  = wstrb;
  assign bus0.write  = write;
  assign bus0.enable = en && (sel == 0);
  assign bus1.addr   = addr;
  assign bus1.wdata  = wdata;
  assign bus1.wstrb  = wstrb;
  assign bus1.write  = write;
  assign bus1.enable = en && (sel == 1);
  assign ready = (sel == 1) ? bus1.ready : bus0.ready;
  assign rdata = (sel == 1) ? bus1.rdata : bus0.rdata;

  bus_ram_responder #(.BASE_ADDR(BASE), .ADDR_WIDTH(10), .READ_LATENCY(2), .WRITE_LATENCY(2))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  bus_ram_responder #(.BASE_ADDR(BASE), .ADDR_WIDTH(10), .READ_LATENCY(1), .WRITE_LATENCY(4))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  typedef struct {
    int          sel;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          lat;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    int          lat;
    logic [31:0] rdata;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int s, logic w, logic [31:0] a, logic [31:0] d, logic [3:0] st,
                              int l, logic [31:0] r);
    vec_t v;
    v.sel = s; v.write = w; v.addr = a; v.wdata = d; v.wstrb = st; v.lat = l; v.rdata = r;
    return v;
  endfunction

  // Request already driven; waits for ready, scrambles the bus after acceptance, then retires.
  task automatic finish_req(input string name);
    exp_t        e;
    int          seen;
    logic [31:0] got;
    seen = 0;
    got  = 32'h0;
    for (int n = 1; n <= 20 && seen == 0; n++) begin
      @(negedge clk);
      if (n == 1) begin
        addr  = ~addr;
        wdata = ~wdata;
      end
      if (ready) begin
        seen = n;
        got  = rdata;
      end
    end
    e = sb.pop_front();
    if (seen == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: no ready within 20 cycles, expected at %0d", name, e.lat);
      en = 1'b0;
      @(negedge clk);
    end else begin
      check({name, " latency"}, 32'(seen), 32'(e.lat));
      check({name, " rdata"}, got, e.rdata);
      @(negedge clk);
      en = 1'b0;
      check({name, " single pulse"}, {31'h0, ready}, 32'h0);
    end
  endtask

  task automatic run_req(input vec_t v, input string name);
    exp_t e;
    e.lat = v.lat;
    e.rdata = v.rdata;
    sb.push_back(e);
    @(negedge clk);
    sel = v.sel; write = v.write; addr = v.addr; wdata = v.wdata; wstrb = v.wstrb; en = 1'b1;
    finish_req(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   hits;
    int   lat_seen[2];
    logic [31:0] dat_seen[2];

    sel = 0; write = 1'b1; addr = BASE; wdata = 32'h1122_3344; wstrb = 4'hF; en = 1'b1;

    // Reset held with a pending request: nothing may complete.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset ready", {31'h0, ready}, 32'h0);
      check("reset rdata", rdata, 32'h0);
    end
    e.lat = 2; e.rdata = 32'h0; sb.push_back(e);
    rst_n = 1'b1;
    finish_req("post-reset write");

    tbl.push_back(mk(0, 1, BASE + 32'h10,  32'hDEAD_BEEF, 4'hF, 2, 32'h0));
    tbl.push_back(mk(0, 0, BASE + 32'h10,  32'h0,         4'h0, 2, 32'hDEAD_BEEF));
    tbl.push_back(mk(0, 1, BASE + 32'h10,  32'h00AA_0000, 4'h4, 2, 32'h0));
    tbl.push_back(mk(0, 0, BASE + 32'h10,  32'h0,         4'h0, 2, 32'hDEAA_BEEF));
    tbl.push_back(mk(0, 1, BASE + 32'h10,  32'hFFFF_FFFF, 4'h0, 2, 32'h0));
    tbl.push_back(mk(0, 0, BASE + 32'h13,  32'h0,         4'h0, 2, 32'hDEAA_BEEF));
    tbl.push_back(mk(0, 0, BASE + 32'h1000, 32'h0,        4'h0, 2, 32'h0));
    tbl.push_back(mk(0, 1, BASE + 32'h1000, 32'hCAFE_F00D, 4'hF, 2, 32'h0));
    tbl.push_back(mk(0, 1, BASE - 32'h4,   32'h5A5A_5A5A, 4'hF, 2, 32'h0));
    tbl.push_back(mk(0, 0, BASE - 32'h4,   32'h0,         4'h0, 2, 32'h0));
    tbl.push_back(mk(0, 0, BASE,           32'h0,         4'h0, 2, 32'h1122_3344));
    tbl.push_back(mk(0, 1, BASE + 32'hFFC, 32'h5566_7788, 4'hF, 2, 32'h0));
    tbl.push_back(mk(0, 1, BASE + 32'hFFC, 32'hA1B2_C3D4, 4'h9, 2, 32'h0));
    tbl.push_back(mk(0, 0, BASE + 32'hFFC, 32'h0,         4'h0, 2, 32'hA166_77D4));
    tbl.push_back(mk(1, 1, BASE,           32'h0102_0304, 4'hF, 4, 32'h0));
    tbl.push_back(mk(1, 1, BASE + 32'h4,   32'h0BAD_C0DE, 4'hF, 4, 32'h0));
    tbl.push_back(mk(1, 1, BASE + 32'h10,  32'hDEAA_BEEF, 4'hF, 4, 32'h0));
    tbl.push_back(mk(1, 0, BASE + 32'h10,  32'h0,         4'h0, 1, 32'hDEAA_BEEF));

    for (int i = 0; i < tbl.size(); i++) begin
      run_req(tbl[i], $sformatf("vec%0d", i));
    end

    // Abort a 4-cycle write while it is still waiting; memory must not change.
    @(negedge clk);
    sel = 1; write = 1'b1; addr = BASE + 32'h10; wdata = 32'h0; wstrb = 4'hF; en = 1'b1;
    @(negedge clk);
    check("abort T+1 ready", {31'h0, ready}, 32'h0);
    @(negedge clk);
    check("abort T+2 ready", {31'h0, ready}, 32'h0);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort idle ready", {31'h0, ready}, 32'h0);
    end
    run_req(mk(1, 0, BASE + 32'h10, 32'h0, 4'h0, 1, 32'hDEAA_BEEF), "after abort read");

    // Back-to-back reads with enable held across the first ready.
    e.lat = 1; e.rdata = 32'h0102_0304; sb.push_back(e);
    e.lat = 3; e.rdata = 32'h0BAD_C0DE; sb.push_back(e);
    @(negedge clk);
    sel = 1; write = 1'b0; addr = BASE; wdata = 32'h0; wstrb = 4'h0; en = 1'b1;
    hits = 0;
    lat_seen[0] = 0; lat_seen[1] = 0; dat_seen[0] = 32'h0; dat_seen[1] = 32'h0;
    for (int n = 1; n <= 10 && hits < 2; n++) begin
      @(negedge clk);
      if (ready) begin
        lat_seen[hits] = n;
        dat_seen[hits] = rdata;
        hits++;
        addr = BASE + 32'h4;
      end
    end
    @(negedge clk);
    en = 1'b0;
    check("b2b gap ready", {31'h0, ready}, 32'h0);
    for (int k = 0; k < 2; k++) begin
      e = sb.pop_front();
      check($sformatf("b2b%0d latency", k), 32'(lat_seen[k]), 32'(e.lat));
      check($sformatf("b2b%0d rdata", k), dat_seen[k], e.rdata);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
